// File: rtl/vector_mem_seq.sv
// Vector load/store sequencer: walks VLEN elements from base_addr by stride,
// one memory access per element, writing loaded elements back to the vector register.
module vector_mem_seq #(
   parameter int VLEN   = 8,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   localparam int EW    = (VLEN > 2) ? $clog2(VLEN) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [EW-1:0]     elem_idx,
   input  logic [DATA_W-1:0] vreg_rdata,
   output logic              vreg_we,
   output logic [DATA_W-1:0] vreg_wdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [EW-1:0] LAST = EW'(VLEN - 1);

   state_t            state_q, state_d;
   logic [EW-1:0]     elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic              st_q, st_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         elem_q   <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         st_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         elem_q   <= elem_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         st_q     <= st_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      elem_d   = elem_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      st_d     = st_q;
      busy     = 1'b0;
      done     = 1'b0;
      mem_req  = 1'b0;
      mem_wr   = 1'b0;
      vreg_we  = 1'b0;
      case (state_q)
         IDLE: begin
            // The base address lives in addr_q from here on; only stride and
            // direction need their own copies.
            if (start) begin
               st_d     = is_store;
               stride_d = stride;
               elem_d   = '0;
               addr_d   = base_addr;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            mem_wr  = st_q;
            if (mem_ack) begin
               vreg_we = ~st_q;
               if (elem_q == LAST) begin
                  state_d = DONE;
               end else begin
                  elem_d = elem_q + 1'b1;
                  addr_d = addr_q + stride_q;
               end
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr   = addr_q;
   assign elem_idx   = elem_q;
   assign mem_wdata  = vreg_rdata;
   assign vreg_wdata = mem_rdata;

endmodule

// File: tb/tb_vector_mem_seq.sv
// Directed bench for vector_mem_seq: load, store with wrap, wait states,
// ignored restart, and reset abort followed by a stride-0 load.
module tb_vector_mem_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [7:0]  base_addr;
   logic [7:0]  stride;
   logic        busy, done, mem_req, mem_wr, mem_ack, vreg_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata, mem_wdata, vreg_rdata, vreg_wdata;
   logic [2:0]  elem_idx;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Simple memory / register-file models with distinct data per address/element
   assign mem_rdata  = {8'hA5, mem_addr};
   assign vreg_rdata = 16'h1000 + {13'd0, elem_idx};

   vector_mem_seq #(.VLEN(8), .ADDR_W(8), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store),
      .base_addr(base_addr), .stride(stride), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .elem_idx(elem_idx),
      .vreg_rdata(vreg_rdata), .vreg_we(vreg_we), .vreg_wdata(vreg_wdata)
   );

   // packed view: {req,wr,we,busy,done,elem[2:0],addr[7:0]}
   function automatic logic [15:0] obs();
      return {mem_req, mem_wr, vreg_we, busy, done, elem_idx, mem_addr};
   endfunction

   task automatic test_reset();
      logic [15:0] exp;
      reset = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = 8'h00;
      stride = 8'h00; mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      exp = 16'h0000;
      n_chk++;
      if (obs() !== exp) begin
         n_fail++; $display("FAIL reset_state got %h exp %h", obs(), exp);
      end
      @(negedge clk); reset = 1'b0;
      mem_ack = 1'b1;   // ack while idle must be ignored
      repeat (2) begin
         @(negedge clk); #1;
         n_chk++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL idle_ack_ignored got %h exp %h", obs(), exp);
         end
      end
   endtask

   task automatic test_load();
      logic [7:0]  a;
      logic [15:0] exp;
      int c0;
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; base_addr = 8'h10; stride = 8'h01; mem_ack = 1'b1;
      c0 = cyc;
      @(negedge clk); start = 1'b0;
      for (int e = 0; e < 8; e++) begin
         #1;
         a = 8'h10 + 8'(e);
         exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'(e), a};
         n_chk++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL load_access e=%0d got %h exp %h", e, obs(), exp);
         end
         n_chk++;
         if (vreg_wdata !== {8'hA5, a}) begin
            n_fail++; $display("FAIL load_wdata e=%0d got %h exp %h", e, vreg_wdata, {8'hA5, a});
         end
         @(negedge clk);
      end
      #1;
      n_chk++;
      if ({done, busy, mem_req, vreg_we} !== 4'b1100 || cyc - c0 != 9) begin
         n_fail++;
         $display("FAIL load_done got d/b/r/w=%b lat=%0d exp 1100 lat=9",
                  {done, busy, mem_req, vreg_we}, cyc - c0);
      end
      @(negedge clk); #1;
      n_chk++;
      if ({done, busy, mem_req} !== 3'b000) begin
         n_fail++; $display("FAIL load_idle got %b exp 000", {done, busy, mem_req});
      end
   endtask

   task automatic test_store_wrap();
      logic [7:0]  a;
      logic [15:0] exp;
      @(negedge clk);
      start = 1'b1; is_store = 1'b1; base_addr = 8'hFE; stride = 8'h01; mem_ack = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int e = 0; e < 8; e++) begin
         #1;
         a = 8'hFE + 8'(e);
         exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'(e), a};
         n_chk++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL store_access e=%0d got %h exp %h", e, obs(), exp);
         end
         n_chk++;
         if (mem_wdata !== 16'h1000 + 16'(e)) begin
            n_fail++; $display("FAIL store_wdata e=%0d got %h exp %h", e, mem_wdata, 16'h1000 + 16'(e));
         end
         @(negedge clk);
      end
      #1;
      n_chk++;
      if ({done, mem_req, vreg_we} !== 3'b100) begin
         n_fail++; $display("FAIL store_done got %b exp 100", {done, mem_req, vreg_we});
      end
      @(negedge clk);
   endtask

   task automatic test_wait_states();
      logic [7:0]  a;
      logic [15:0] exp;
      int c0, nwe;
      nwe = 0;
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; base_addr = 8'h40; stride = 8'h03; mem_ack = 1'b1;
      c0 = cyc;
      @(negedge clk); start = 1'b0;
      for (int e = 0; e < 8; e++) begin
         a = 8'h40 + 8'(3 * e);
         if (e == 2) begin
            for (int w = 0; w < 3; w++) begin
               mem_ack = 1'b0; #1;
               exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(e), a};
               n_chk++;
               if (obs() !== exp) begin
                  n_fail++; $display("FAIL wait_hold w=%0d got %h exp %h", w, obs(), exp);
               end
               @(negedge clk);
            end
         end
         mem_ack = 1'b1; #1;
         if (e == 2 && vreg_we === 1'b1) nwe++;
         exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'(e), a};
         n_chk++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL wait_access e=%0d got %h exp %h", e, obs(), exp);
         end
         @(negedge clk);
      end
      #1;
      n_chk++;
      if (done !== 1'b1 || cyc - c0 != 12 || nwe != 1) begin
         n_fail++;
         $display("FAIL wait_done got done=%b lat=%0d we2=%0d exp done=1 lat=12 we2=1",
                  done, cyc - c0, nwe);
      end
      @(negedge clk);
   endtask

   task automatic test_restart_ignored();
      logic [7:0]  a;
      logic [15:0] exp;
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; base_addr = 8'h20; stride = 8'h02; mem_ack = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int e = 0; e < 8; e++) begin
         if (e == 3) begin
            start = 1'b1; is_store = 1'b1; base_addr = 8'h80; stride = 8'h05;
         end else begin
            start = 1'b0;
         end
         #1;
         a = 8'h20 + 8'(2 * e);
         exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'(e), a};
         n_chk++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL restart_access e=%0d got %h exp %h", e, obs(), exp);
         end
         @(negedge clk);
      end
      start = 1'b0; is_store = 1'b0;
      #1;
      n_chk++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL restart_done got %b exp 1", done);
      end
      @(negedge clk); #1;
      n_chk++;
      if ({busy, mem_req} !== 2'b00) begin
         n_fail++; $display("FAIL restart_idle got %b exp 00", {busy, mem_req});
      end
   endtask

   task automatic test_reset_abort();
      logic [15:0] exp;
      int seen;
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; base_addr = 8'h30; stride = 8'h01; mem_ack = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 8'h34};
      n_chk++;
      if (obs() !== exp) begin
         n_fail++; $display("FAIL abort_elem4 got %h exp %h", obs(), exp);
      end
      reset = 1'b1; #1;
      n_chk++;
      if (obs() !== 16'h0000) begin
         n_fail++; $display("FAIL abort_immediate got %h exp 0000", obs());
      end
      @(negedge clk); reset = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (done || mem_req || busy) seen++;
      end
      n_chk++;
      if (seen != 0) begin
         n_fail++; $display("FAIL abort_quiet got %0d active cycles exp 0", seen);
      end
      start = 1'b1; is_store = 1'b0; base_addr = 8'h55; stride = 8'h00;
      @(negedge clk); start = 1'b0;
      for (int e = 0; e < 8; e++) begin
         #1;
         exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'(e), 8'h55};
         n_chk++;
         if (obs() !== exp) begin
            n_fail++; $display("FAIL stride0_access e=%0d got %h exp %h", e, obs(), exp);
         end
         @(negedge clk);
      end
      #1;
      n_chk++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL stride0_done got %b exp 1", done);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_wrap();
      test_wait_states();
      test_restart_ignored();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
